// File: rtl/led_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter_pkg
// Brief    : Shared state encoding and constants for the LED arbiter.
// Revision : 1.0
// ============================================================================
package led_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int C_LED_W_DEFAULT = 8;
    localparam int C_PWM_W         = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first set req bit at or after
//            start, wrapping around. Returns a one-hot pick and a valid flag.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    always_comb begin
        int sum;
        pick  = '0;
        valid = 1'b0;
        sum   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = int'(start) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (!valid && req[sum]) begin
                pick[sum] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter
// Brief    : Round-robin LED bus arbiter with minimum dwell and a one-cycle
//            dark gap between owners. LED_ARBITER_PWM_EN adds brightness PWM.
// Revision : 1.0
// ============================================================================
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 2500000,
    parameter int LED_W        = C_LED_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef LED_ARBITER_PWM_EN
    input  logic [C_PWM_W-1:0]       brightness,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] req_pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LED_W-1:0]         io_leds
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [LED_W-1:0]     io_leds_q, io_leds_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;

    logic [IDX_W-1:0]     search_start;
    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [LED_W-1:0]     owner_pat;
    logic                 owner_req;
    logic                 others_waiting;
    logic                 led_en;

    assign search_start = (last_owner_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : last_owner_q + IDX_W'(1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .start (search_start),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // last_owner_q tracks the current owner for the whole OWNED tenure.
    assign owner_pat      = req_pattern[int'(last_owner_q)*LED_W +: LED_W];
    assign owner_req      = |(req & grant_q);
    assign others_waiting = |(req & ~grant_q);

`ifdef LED_ARBITER_PWM_EN
    logic [C_PWM_W-1:0] pwm_cnt_q;
    logic [C_PWM_W-1:0] pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + C_PWM_W'(1);
    assign led_en    = (pwm_cnt_q < brightness);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    assign led_en = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        io_leds_d    = '0;
        dwell_d      = (dwell_q != '0) ? dwell_q - DWELL_W'(1) : '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d      = OWNED;
                    grant_d      = pick;
                    last_owner_d = pick_idx;
                    dwell_d      = DWELL_W'(DWELL_CYCLES - 1);
                end
            end
            OWNED: begin
                // A dropped request wins over preemption and over new arrivals.
                if (!owner_req || ((dwell_q == '0) && others_waiting)) begin
                    state_d = GAP;
                    grant_d = '0;
                end else if (led_en) begin
                    io_leds_d = owner_pat;
                end
            end
            GAP: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            io_leds_q    <= '0;
            dwell_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            io_leds_q    <= io_leds_d;
            dwell_q      <= dwell_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant   = grant_q;
    assign io_leds = io_leds_q;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_arbiter
// Brief    : Directed scoreboard bench for led_arbiter (4 req, dwell 4, 8 LEDs).
// Revision : 1.0
// ============================================================================
module tb_led_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LED_W   = 8;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_pattern;
    logic [NUM_REQ-1:0]       grant;
    logic [LED_W-1:0]         io_leds;
`ifdef LED_ARBITER_PWM_EN
    logic [7:0]               brightness;
`endif

    typedef struct {
        string            tag;
        logic [3:0]       g;
        logic [7:0]       l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    led_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DWELL_CYCLES (4),
        .LED_W        (LED_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef LED_ARBITER_PWM_EN
        .brightness  (brightness),
`endif
        .req         (req),
        .req_pattern (req_pattern),
        .grant       (grant),
        .io_leds     (io_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, checks=%0d required=done", checks);
        $fatal(1, "timeout");
    end

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert ({grant, io_leds} === {e.g, e.l}) else begin
            errors++;
            $error("FAIL %s: grant=%b io_leds=%h expected grant=%b io_leds=%h",
                   e.tag, grant, io_leds, e.g, e.l);
        end
    endtask

    task automatic check_now(input logic [3:0] g, input logic [7:0] l, input string tag);
        sb.push_back('{tag, g, l});
        compare_head();
    endtask

    task automatic step(input logic [3:0] g, input logic [7:0] l, input string tag);
        sb.push_back('{tag, g, l});
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        reset       = 1'b0;
        req         = '0;
        req_pattern = {8'hC3, 8'h0F, 8'h3C, 8'hA5};
`ifdef LED_ARBITER_PWM_EN
        brightness  = 8'd64;
`endif
        #2;
        check_now(4'b0000, 8'h00, "reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifdef LED_ARBITER_PWM_EN
        begin
            int on_cnt;
            int bad_cnt;
            on_cnt  = 0;
            bad_cnt = 0;
            req_pattern[7:0] = 8'hFF;
            req = 4'b0001;
            step(4'b0001, 8'h00, "pwm_grant");
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < 256; i++) begin
                @(posedge clk);
                #1;
                if (io_leds === 8'hFF) on_cnt++;
                else if (io_leds !== 8'h00) bad_cnt++;
            end
            checks++;
            assert (on_cnt === 64) else begin
                errors++;
                $error("FAIL pwm_duty: on_cycles=%0d expected=%0d", on_cnt, 64);
            end
            checks++;
            assert (bad_cnt === 0) else begin
                errors++;
                $error("FAIL pwm_levels: bad_cycles=%0d expected=%0d", bad_cnt, 0);
            end
        end
`else
        // First grant after reset starts the search at requester 0.
        req = 4'b0001;
        step(4'b0001, 8'h00, "a_grant");
        step(4'b0001, 8'hA5, "a_leds");
        req_pattern[7:0] = 8'h5A;
        check_now(4'b0001, 8'hA5, "a_lag_hold");
        step(4'b0001, 8'h5A, "a_lag_update");

        // Asynchronous reset in the middle of ownership.
        #2;
        reset = 1'b0;
        #1;
        check_now(4'b0000, 8'h00, "a_async_rst");
        @(posedge clk);
        #1;
        reset            = 1'b1;
        req              = '0;
        req_pattern[7:0] = 8'hA5;
        step(4'b0000, 8'h00, "a_idle_after_rst");

        // Dwell expiry with a waiting requester.
        req = 4'b0011;
        step(4'b0001, 8'h00, "b_grant0");
        for (int i = 0; i < 3; i++) step(4'b0001, 8'hA5, "b_own0");
        step(4'b0000, 8'h00, "b_gap");
        step(4'b0000, 8'h00, "b_idle");
        step(4'b0010, 8'h00, "b_grant1");
        step(4'b0010, 8'h3C, "b_own1");
        req = 4'b0000;
        step(4'b0000, 8'h00, "b_gap2");
        step(4'b0000, 8'h00, "b_idle2");

        // Owner drops early while another request rises in the same cycle.
        req = 4'b0100;
        step(4'b0100, 8'h00, "c_grant2");
        step(4'b0100, 8'h0F, "c_own2");
        req = 4'b0010;
        step(4'b0000, 8'h00, "c_drop_gap");
        step(4'b0000, 8'h00, "c_idle");
        step(4'b0010, 8'h00, "c_grant1");
        step(4'b0010, 8'h3C, "c_own1");
        req = 4'b0000;
        step(4'b0000, 8'h00, "c_gap");
        step(4'b0000, 8'h00, "c_idle2");

        // Make requester 3 the last owner, then check wrap-around to 0.
        req = 4'b1000;
        step(4'b1000, 8'h00, "d_grant3");
        step(4'b1000, 8'hC3, "d_own3");
        req = 4'b0000;
        step(4'b0000, 8'h00, "d_gap");
        step(4'b0000, 8'h00, "d_idle");
        req = 4'b1001;
        step(4'b0001, 8'h00, "d_wrap_grant0");
        for (int i = 0; i < 3; i++) step(4'b0001, 8'hA5, "d_own0");
        step(4'b0000, 8'h00, "d_preempt_gap");
        step(4'b0000, 8'h00, "d_preempt_idle");
        step(4'b1000, 8'h00, "d_grant3b");
        step(4'b1000, 8'hC3, "d_own3b");

        // Sole requester keeps ownership indefinitely, then is re-granted.
        req = 4'b1000;
        for (int i = 0; i < 8; i++) step(4'b1000, 8'hC3, "e_no_timeout");
        req = 4'b0000;
        step(4'b0000, 8'h00, "e_gap");
        req = 4'b1000;
        step(4'b0000, 8'h00, "e_idle");
        step(4'b1000, 8'h00, "e_regrant");
        step(4'b1000, 8'hC3, "e_own");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
